// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control slice.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef logic [REG_ADDR_W_DEF-1:0] reg_idx_t;

    typedef enum logic {
        HZ_RUN,
        HZ_LU_STALL
    } hz_state_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is always written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / memory-freeze hazard controller for the 5-stage RV32 pipeline.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_rs1_used,
    input  logic                  if_id_rs2_used,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_busy,
    input  logic                  stat_clr,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  control_mux_sig,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int SL_W = $clog2(LOAD_USE_STALL + 1);

    hz_state_t       state_q, state_d;
    logic [SL_W-1:0] stall_left_q, stall_left_d;
    logic            hz;

    assign hz = id_ex_mem_read
              && (id_ex_rd != REG_ADDR_W'(REG_ZERO))
              && ((if_id_rs1_used && (id_ex_rd == if_id_rs1))
               || (if_id_rs2_used && (id_ex_rd == if_id_rs2)));

    // NOTE: reset is synchronous, so it is sampled only on the rising clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HZ_RUN;
            stall_left_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no path infers a latch.
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_write     = 1'b1;
        ex_mem_write    = 1'b1;
        control_mux_sig = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        state_d         = state_q;
        stall_left_d    = stall_left_q;

        if (!rst_n) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_write     = 1'b0;
            ex_mem_write    = 1'b0;
            control_mux_sig = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            state_d         = HZ_RUN;
            stall_left_d    = '0;
        end else if (dmem_busy) begin
            // Whole pipe holds; state and any unresolved branch are simply re-seen later.
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_write     = 1'b0;
            ex_mem_write    = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            state_d         = HZ_RUN;
            stall_left_d    = '0;
        end else if ((state_q == HZ_LU_STALL) || hz) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            control_mux_sig = 1'b1;
            if (state_q == HZ_LU_STALL) begin
                // hz is ignored here: EX now holds a bubble, not the load.
                if (stall_left_q == SL_W'(1)) begin
                    state_d      = HZ_RUN;
                    stall_left_d = '0;
                end else begin
                    stall_left_d = stall_left_q - SL_W'(1);
                end
            end else if (LOAD_USE_STALL > 1) begin
                state_d      = HZ_LU_STALL;
                stall_left_d = SL_W'(LOAD_USE_STALL - 1);
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

endmodule
